// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI link: TX state encoding and bus constants.
package ulpi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    STP  = 2'd2
  } tx_state_e;

  // Byte driven on the bus whenever the link has nothing to say.
  localparam logic [7:0] ULPI_NOOP = 8'h00;

  // Upper two bits of a TX CMD byte select the command class.
  localparam logic [1:0] TXCMD_TRANSMIT  = 2'b01;
  localparam logic [1:0] TXCMD_REG_WRITE = 2'b10;
  localparam logic [1:0] TXCMD_REG_READ  = 2'b11;

endpackage

// File: rtl/ulpi_link_if.sv
// ULPI bus signals shared between the link (master) and the PHY (slave).
interface ulpi_link_if;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;

  modport master (
    input  ulpi_data_in,
    input  ulpi_dir,
    input  ulpi_nxt,
    output ulpi_data_out,
    output ulpi_data_oe,
    output ulpi_stp
  );

  modport slave (
    output ulpi_data_in,
    output ulpi_dir,
    output ulpi_nxt,
    input  ulpi_data_out,
    input  ulpi_data_oe,
    input  ulpi_stp
  );
endinterface

// File: rtl/ulpi_rx_decode.sv
// Receive side: tracks bus ownership and splits PHY bytes into USB data and RX CMD.
module ulpi_rx_decode
  import ulpi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic       dir_q,
  output logic [7:0] data,
  output logic       data_valid,
  output logic [7:0] rx_cmd
);

  logic phy_owns;

  // Bytes are only meaningful once the PHY has held dir for a full cycle;
  // the first cycle after a dir change is turnaround.
  assign phy_owns = ulpi_dir && dir_q;

  // Register dir and capture either a data byte (nxt=1) or an RX CMD (nxt=0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q      <= 1'b0;
      data       <= ULPI_NOOP;
      data_valid <= 1'b0;
      rx_cmd     <= ULPI_NOOP;
    end else begin
      dir_q      <= ulpi_dir;
      data_valid <= phy_owns && ulpi_nxt;
      if (phy_owns && ulpi_nxt) begin
        data <= ulpi_data_in;
      end
      if (phy_owns && !ulpi_nxt) begin
        rx_cmd <= ulpi_data_in;
      end
    end
  end

endmodule

// File: rtl/ulpi_link.sv
// ULPI link top: RX decode plus a small TX CMD state machine.
module ulpi_link
  import ulpi_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ulpi_link_if.master   bus,
  output logic [7:0]    data,
  output logic          data_valid,
  output logic [7:0]    rx_cmd,
  input  logic [7:0]    cmd,
  input  logic          cmd_strobe,
  output logic          cmd_busy
);

  tx_state_e  state, state_nxt;
  logic [7:0] cmd_reg, cmd_reg_nxt;
  logic       dir_q;
  logic       bus_free;
  logic [7:0] data_out_c;
  logic       oe_c;
  logic       stp_c;

  ulpi_rx_decode u_rx (
    .clk          (clk),
    .reset        (reset),
    .ulpi_dir     (bus.ulpi_dir),
    .ulpi_nxt     (bus.ulpi_nxt),
    .ulpi_data_in (bus.ulpi_data_in),
    .dir_q        (dir_q),
    .data         (data),
    .data_valid   (data_valid),
    .rx_cmd       (rx_cmd)
  );

  // The link may drive only when the PHY has released the bus for a full cycle.
  assign bus_free = !bus.ulpi_dir && !dir_q;

  // State and latched command; reset drops any command without a stop strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cmd_reg <= ULPI_NOOP;
    end else begin
      state   <= state_nxt;
      cmd_reg <= cmd_reg_nxt;
    end
  end

  // Next state and bus outputs; a dir rise mid-command just pauses driving.
  always_comb begin
    state_nxt   = state;
    cmd_reg_nxt = cmd_reg;
    data_out_c  = ULPI_NOOP;
    oe_c        = 1'b0;
    stp_c       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_strobe) begin
          cmd_reg_nxt = cmd;
          state_nxt   = CMD;
        end
      end
      CMD: begin
        if (bus_free) begin
          data_out_c = cmd_reg;
          oe_c       = 1'b1;
        end
        if (bus.ulpi_nxt && !bus.ulpi_dir) begin
          state_nxt = STP;
        end
      end
      STP: begin
        stp_c     = 1'b1;
        oe_c      = bus_free;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ulpi_data_out = data_out_c;
  assign bus.ulpi_data_oe  = oe_c;
  assign bus.ulpi_stp      = stp_c;
  assign cmd_busy          = (state != IDLE);

endmodule

// File: tb/tb_ulpi_link.sv
// Bench for ulpi_link: directed ULPI scenarios plus a random run against a reference model.
module tb_ulpi_link;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       cmd_strobe = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic [7:0] rx_cmd;
  logic       cmd_busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  ulpi_link_if u_if ();

  ulpi_link dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (u_if),
    .data       (data),
    .data_valid (data_valid),
    .rx_cmd     (rx_cmd),
    .cmd        (cmd),
    .cmd_strobe (cmd_strobe),
    .cmd_busy   (cmd_busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the link has observed and promised, in protocol terms.
  bit       m_dir_prev = 0;
  bit       m_pending  = 0;
  bit       m_stopping = 0;
  bit [7:0] m_cmd      = 0;
  bit [7:0] m_data     = 0;
  bit       m_valid    = 0;
  bit [7:0] m_rx_cmd   = 0;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic d, input logic n,
                                input logic [7:0] din, input logic s, input logic [7:0] c);
    @(negedge clk);
    reset            = rst_n;
    u_if.ulpi_dir     = d;
    u_if.ulpi_nxt     = n;
    u_if.ulpi_data_in = din;
    cmd_strobe       = s;
    cmd              = c;
    #2;
  endtask

  // Advance the model once per rising edge from the inputs the PHY and user presented.
  always @(posedge clk) begin
    if (!reset) begin
      m_dir_prev <= 0;
      m_pending  <= 0;
      m_stopping <= 0;
      m_cmd      <= 0;
      m_data     <= 0;
      m_valid    <= 0;
      m_rx_cmd   <= 0;
    end else begin
      m_valid <= u_if.ulpi_dir && m_dir_prev && u_if.ulpi_nxt;
      if (u_if.ulpi_dir && m_dir_prev && u_if.ulpi_nxt) m_data <= u_if.ulpi_data_in;
      if (u_if.ulpi_dir && m_dir_prev && !u_if.ulpi_nxt) m_rx_cmd <= u_if.ulpi_data_in;
      if (!m_pending) begin
        if (cmd_strobe) begin
          m_pending <= 1;
          m_cmd     <= cmd;
        end
      end else if (m_stopping) begin
        m_pending  <= 0;
        m_stopping <= 0;
      end else if (u_if.ulpi_nxt && !u_if.ulpi_dir) begin
        m_stopping <= 1;
      end
      m_dir_prev <= u_if.ulpi_dir;
    end
  end

  // Compare every output against the model once inputs have settled in each cycle.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      bit       free;
      bit [7:0] exp_out;
      free    = !u_if.ulpi_dir && !m_dir_prev;
      exp_out = (m_pending && !m_stopping && free) ? m_cmd : 8'h00;
      check_output("oe",       {7'b0, u_if.ulpi_data_oe}, {7'b0, m_pending && free});
      check_output("stp",      {7'b0, u_if.ulpi_stp},     {7'b0, m_stopping});
      check_output("data_out", u_if.ulpi_data_out,        exp_out);
      check_output("busy",     {7'b0, cmd_busy},          {7'b0, m_pending});
      check_output("valid",    {7'b0, data_valid},        {7'b0, m_valid});
      check_output("data",     data,                      m_data);
      check_output("rx_cmd",   rx_cmd,                    m_rx_cmd);
    end
  end

  initial begin
    u_if.ulpi_dir     = 1'b0;
    u_if.ulpi_nxt     = 1'b0;
    u_if.ulpi_data_in = 8'h00;

    apply_stimulus(0, 0, 0, 8'h00, 0, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    chk_en = 1'b1;
    check_output("rst_busy", {7'b0, cmd_busy}, 8'h00);
    check_output("rst_out",  u_if.ulpi_data_out, 8'h00);
    check_output("rst_rxc",  rx_cmd, 8'h00);

    // RX: turnaround (nxt high but ignored), RX CMD, two data bytes, turnaround back.
    apply_stimulus(1, 1, 1, 8'hFF, 0, 8'h00);
    check_output("rx_ta_oe", {7'b0, u_if.ulpi_data_oe}, 8'h00);
    apply_stimulus(1, 1, 0, 8'h4D, 0, 8'h00);
    check_output("rx_ta_valid", {7'b0, data_valid}, 8'h00);
    check_output("rx_ta_data",  data, 8'h00);
    apply_stimulus(1, 1, 1, 8'hA5, 0, 8'h00);
    check_output("rx_cmd_4d", rx_cmd, 8'h4D);
    apply_stimulus(1, 1, 1, 8'h3C, 0, 8'h00);
    check_output("rx_a5_valid", {7'b0, data_valid}, 8'h01);
    check_output("rx_a5",       data, 8'hA5);
    apply_stimulus(1, 0, 0, 8'h77, 0, 8'h00);
    check_output("rx_3c_valid", {7'b0, data_valid}, 8'h01);
    check_output("rx_3c",       data, 8'h3C);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("rx_end_valid", {7'b0, data_valid}, 8'h00);
    check_output("rx_end_data",  data, 8'h3C);
    check_output("rx_end_rxc",   rx_cmd, 8'h4D);

    // TX with a second strobe (8'h55) while busy that must be ignored.
    apply_stimulus(1, 0, 0, 8'h00, 1, 8'h41);
    check_output("tx_pre_busy", {7'b0, cmd_busy}, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 1, 8'h55);
    check_output("tx_d1_out", u_if.ulpi_data_out, 8'h41);
    check_output("tx_d1_oe",  {7'b0, u_if.ulpi_data_oe}, 8'h01);
    apply_stimulus(1, 0, 1, 8'h00, 0, 8'h00);
    check_output("tx_d2_out", u_if.ulpi_data_out, 8'h41);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("tx_stp",     {7'b0, u_if.ulpi_stp}, 8'h01);
    check_output("tx_stp_out", u_if.ulpi_data_out, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("tx_done_busy", {7'b0, cmd_busy}, 8'h00);
    check_output("tx_done_stp",  {7'b0, u_if.ulpi_stp}, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("tx_no55_busy", {7'b0, cmd_busy}, 8'h00);

    // Abort: PHY takes the bus mid-command, then the command is re-driven.
    apply_stimulus(1, 0, 0, 8'h00, 1, 8'h41);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("ab_drive", u_if.ulpi_data_out, 8'h41);
    apply_stimulus(1, 1, 0, 8'h00, 0, 8'h00);
    check_output("ab_oe_drop", {7'b0, u_if.ulpi_data_oe}, 8'h00);
    check_output("ab_out_drop", u_if.ulpi_data_out, 8'h00);
    apply_stimulus(1, 1, 0, 8'h12, 0, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("ab_ta_oe", {7'b0, u_if.ulpi_data_oe}, 8'h00);
    check_output("ab_busy",  {7'b0, cmd_busy}, 8'h01);
    apply_stimulus(1, 0, 1, 8'h00, 0, 8'h00);
    check_output("ab_redrive", u_if.ulpi_data_out, 8'h41);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("ab_stp", {7'b0, u_if.ulpi_stp}, 8'h01);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);

    // Strobe arriving while the PHY owns the bus is held until the bus returns.
    apply_stimulus(1, 1, 0, 8'h00, 1, 8'h9C);
    apply_stimulus(1, 1, 0, 8'h00, 0, 8'h00);
    check_output("sim_busy", {7'b0, cmd_busy}, 8'h01);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    apply_stimulus(1, 0, 1, 8'h00, 0, 8'h00);
    check_output("sim_out", u_if.ulpi_data_out, 8'h9C);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);

    // Reset during CMD: everything clears and no stop strobe follows.
    apply_stimulus(1, 0, 0, 8'h00, 1, 8'h41);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    apply_stimulus(0, 0, 1, 8'h00, 0, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("rs_busy", {7'b0, cmd_busy}, 8'h00);
    check_output("rs_oe",   {7'b0, u_if.ulpi_data_oe}, 8'h00);
    check_output("rs_stp",  {7'b0, u_if.ulpi_stp}, 8'h00);
    check_output("rs_rxc",  rx_cmd, 8'h00);
    check_output("rs_data", data, 8'h00);
    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    check_output("rs_stp2", {7'b0, u_if.ulpi_stp}, 8'h00);

    // Random traffic with sticky dir runs and rare resets.
    begin
      logic d;
      d = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) d = ~d;
        apply_stimulus(($urandom_range(0, 99) != 0), d, 1'($urandom_range(0, 1)),
                       8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
      end
    end

    apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
